// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: controller state encoding,
// access-direction constants and default bus widths used by MAR/MDR and
// the Load/Store sequencers.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 16;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    REARM = 2'd3
  } mem_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with a registered read port.
// The read register only updates when re is high, so the last read value
// is held indefinitely. Contents are never cleared.
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Write port and enabled registered read share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_ctrl_mfc.sv
// Main-memory controller with MFC handshake for the Load/Store sequencers.
// A request is latched in IDLE, waits a fixed read/write latency, performs
// the array access on the edge into ACK, pulses MFC low for one cycle and
// then parks in REARM until the requester drops mem_en.
// Optional build macro: MEM_BOUNDS_CHK_EN adds the mem_err output, which
// flags out-of-range accesses during their ACK cycle.
module mem_ctrl_mfc
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              MFC,
  output logic              busy
`ifdef MEM_BOUNDS_CHK_EN
  ,
  output logic              mem_err
`endif
);

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = cnt_width(LAT_MAX - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              rd_zero_reg;
  logic              in_range;
  logic              launch;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range = ({1'b0, addr_reg} < DEPTH_EXT);
  // The edge leaving WAIT with an expired counter is the ACK-entry edge,
  // which is where the array is actually accessed.
  assign launch   = (state_reg == WAIT) && (cnt_reg == '0);
  assign ram_we   = launch && (rw_reg == MEM_WRITE) && in_range;
  assign ram_re   = launch && (rw_reg == MEM_READ) && in_range;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latches, latency counter and the zero-read flag for rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      rw_reg      <= MEM_WRITE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rd_zero_reg <= 1'b1;
    end else begin
      if (state_reg == IDLE) begin
        if (mem_en) begin
          rw_reg    <= mem_rw;
          addr_reg  <= addr;
          wdata_reg <= wdata;
          cnt_reg   <= (mem_rw == MEM_READ) ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
        end
      end else if (state_reg == WAIT) begin
        if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
      // A read result (real or forced zero) is taken on ACK entry; writes
      // leave the previous read result untouched.
      if (launch && (rw_reg == MEM_READ)) begin
        rd_zero_reg <= ~in_range;
      end
    end
  end

  // Next-state logic. Every access spends at least one cycle in WAIT so
  // that MFC falls exactly LAT edges after acceptance, also when LAT is 1.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_en) state_next = WAIT;
      WAIT:    if (cnt_reg == '0) state_next = ACK;
      ACK:     state_next = REARM;
      REARM:   if (!mem_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only; no input reaches MFC or busy.
  always_comb begin
    MFC  = (state_reg != ACK);
    busy = (state_reg != IDLE);
`ifdef MEM_BOUNDS_CHK_EN
    mem_err = (state_reg == ACK) && !in_range;
`endif
  end

  assign rdata = rd_zero_reg ? '0 : ram_rdata;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_ctrl_mfc.sv
// Bench for mem_ctrl_mfc: a default instance (RD_LAT=3, WR_LAT=2, DEPTH=256)
// and a boundary instance (RD_LAT=WR_LAT=1, DEPTH=200) share clock and reset.
// A timeline model (acceptance time + latency, a word array, a last-read
// value) predicts MFC/busy/rdata every cycle; directed transactions add
// literal expectations.
module tb_mem_ctrl_mfc;

  logic        clk = 1'b0;
  logic        reset;
  logic        en    [2];
  logic        rw    [2];
  logic [7:0]  a     [2];
  logic [15:0] wd    [2];
  logic [15:0] rd    [2];
  logic        mfc   [2];
  logic        bsy   [2];
`ifdef MEM_BOUNDS_CHK_EN
  logic        err   [2];
`endif

  always #5 clk = ~clk;

  mem_ctrl_mfc dut_a (
    .clk    (clk),
    .reset  (reset),
    .mem_en (en[0]),
    .mem_rw (rw[0]),
    .addr   (a[0]),
    .wdata  (wd[0]),
    .rdata  (rd[0]),
    .MFC    (mfc[0]),
    .busy   (bsy[0])
`ifdef MEM_BOUNDS_CHK_EN
    ,
    .mem_err(err[0])
`endif
  );

  mem_ctrl_mfc #(.DEPTH(200), .RD_LAT(1), .WR_LAT(1)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .mem_en (en[1]),
    .mem_rw (rw[1]),
    .addr   (a[1]),
    .wdata  (wd[1]),
    .rdata  (rd[1]),
    .MFC    (mfc[1]),
    .busy   (bsy[1])
`ifdef MEM_BOUNDS_CHK_EN
    ,
    .mem_err(err[1])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          lrd [2] = '{3, 1};
  int          lwr [2] = '{2, 1};
  int          dep [2] = '{256, 200};
  int          cyc = 0;
  bit          m_active [2];
  int          m_tack   [2];
  logic        m_rw     [2];
  logic [7:0]  m_a      [2];
  logic [15:0] m_d      [2];
  logic [15:0] m_rd     [2];
  bit          m_rdk    [2];
  logic        m_mfc    [2];
  logic        m_err    [2];
  logic [15:0] m_mem    [2][256];
  bit          m_val    [2][256];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0;
        m_rd[i]     = 16'h0;
        m_rdk[i]    = 1;
        m_mfc[i]    = 1'b1;
        m_err[i]    = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!m_active[i]) begin
          if (en[i]) begin
            m_active[i] = 1;
            m_rw[i]     = rw[i];
            m_a[i]      = a[i];
            m_d[i]      = wd[i];
            m_tack[i]   = cyc + (rw[i] ? lrd[i] : lwr[i]);
          end
        end else if (cyc == m_tack[i]) begin
          if (int'(m_a[i]) < dep[i]) begin
            if (m_rw[i]) begin
              m_rd[i]  = m_mem[i][m_a[i]];
              m_rdk[i] = m_val[i][m_a[i]];
            end else begin
              m_mem[i][m_a[i]] = m_d[i];
              m_val[i][m_a[i]] = 1;
            end
          end else if (m_rw[i]) begin
            m_rd[i]  = 16'h0;
            m_rdk[i] = 1;
          end
        end else if (cyc > m_tack[i] + 1 && !en[i]) begin
          m_active[i] = 0;
        end
        m_mfc[i] = !(m_active[i] && cyc == m_tack[i]);
        m_err[i] = !m_mfc[i] && (int'(m_a[i]) >= dep[i]);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cyc mfc[%0d]", i), 32'(mfc[i]), 32'(m_mfc[i]));
        check($sformatf("cyc busy[%0d]", i), 32'(bsy[i]), 32'(m_active[i]));
        if (m_rdk[i]) check($sformatf("cyc rdata[%0d]", i), 32'(rd[i]), 32'(m_rd[i]));
`ifdef MEM_BOUNDS_CHK_EN
        check($sformatf("cyc mem_err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
`endif
      end
    end
  end

  // One access: called #1 after an edge with the instance idle; holds EN
  // until MFC is seen low, then drops it and waits for busy to clear.
  task automatic access(input int i, input logic r, input logic [7:0] ad, input logic [15:0] d,
                        input bit glitch, output int lat, output logic [15:0] rdm, output logic errm);
    en[i] = 1'b1; rw[i] = r; a[i] = ad; wd[i] = d;
    @(posedge clk); #1;
    if (glitch) begin
      a[i]  = ad + 8'd1;
      wd[i] = ~d;
    end
    lat = 0; rdm = 'x; errm = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mfc[i] === 1'b0) begin
        lat = k;
        rdm = rd[i];
`ifdef MEM_BOUNDS_CHK_EN
        errm = err[i];
`endif
        break;
      end
    end
    if (lat == 0) check("mfc timeout", 32'(lat), 32'(1));
    en[i] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bsy[i] === 1'b0) break;
    end
    check("busy clears", 32'(bsy[i]), 32'(0));
    $display("txn inst=%0d %s addr=%02h wdata=%04h lat=%0d rdata=%04h", i, r ? "RD" : "WR", ad, d, lat, rdm);
  endtask

  int          lat;
  logic [15:0] rdm;
  logic        errm;
  int          pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en[i] = 0; rw[i] = 0; a[i] = 0; wd[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset mfc", 32'(mfc[i]), 32'(1));
      check("reset busy", 32'(bsy[i]), 32'(0));
      check("reset rdata", 32'(rd[i]), 32'(0));
    end
    reset = 1'b0;
    started = 1;
    @(posedge clk); #1;

    // 1. write then read, latency and rdata hold
    access(0, 1'b0, 8'h12, 16'hBEEF, 0, lat, rdm, errm);
    check("wr latency", 32'(lat), 32'(2));
    access(0, 1'b1, 8'h12, 16'h0000, 0, lat, rdm, errm);
    check("rd latency", 32'(lat), 32'(3));
    check("rd beef at mfc", 32'(rdm), 32'hBEEF);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rdata hold", 32'(rd[0]), 32'hBEEF);
    end

    // 2. held enable gives one access only
    access(0, 1'b0, 8'h06, 16'h0606, 0, lat, rdm, errm);
    access(0, 1'b0, 8'h05, 16'h0505, 0, lat, rdm, errm);
    en[0] = 1; rw[0] = 1; a[0] = 8'h05;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (mfc[0] === 1'b0) pulses++;
    end
    check("held en pulses", 32'(pulses), 32'(1));
    check("held en busy", 32'(bsy[0]), 32'(1));
    check("held en rdata", 32'(rd[0]), 32'h0505);
    en[0] = 0;
    @(posedge clk); #1;
    en[0] = 1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (mfc[0] === 1'b0) pulses++;
    end
    check("rearm pulses", 32'(pulses), 32'(1));
    en[0] = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("txn inst=0 RD held-enable addr=05 pulses=%0d", pulses);

    // 3. inputs ignored while busy
    access(0, 1'b0, 8'h05, 16'h5A5A, 1, lat, rdm, errm);
    access(0, 1'b1, 8'h06, 16'h0000, 0, lat, rdm, errm);
    check("addr 06 untouched", 32'(rdm), 32'h0606);
    access(0, 1'b1, 8'h05, 16'h0000, 0, lat, rdm, errm);
    check("addr 05 latched", 32'(rdm), 32'h5A5A);

    // 6. writes do not disturb rdata
    access(0, 1'b0, 8'h31, 16'h5555, 0, lat, rdm, errm);
    access(0, 1'b1, 8'h31, 16'h0000, 0, lat, rdm, errm);
    check("rd 5555", 32'(rdm), 32'h5555);
    access(0, 1'b0, 8'h30, 16'hAAAA, 0, lat, rdm, errm);
    check("rdata through wr ack", 32'(rdm), 32'h5555);
    check("rdata after wr", 32'(rd[0]), 32'h5555);
    access(0, 1'b1, 8'h30, 16'h0000, 0, lat, rdm, errm);
    check("rd aaaa", 32'(rdm), 32'hAAAA);

    // 4. reset in the WAIT cycle of a write
    access(0, 1'b0, 8'h20, 16'h0F0F, 0, lat, rdm, errm);
    en[0] = 1; rw[0] = 0; a[0] = 8'h20; wd[0] = 16'h1234;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst mfc", 32'(mfc[0]), 32'(1));
    check("midrst busy", 32'(bsy[0]), 32'(0));
    check("midrst rdata", 32'(rd[0]), 32'(0));
    en[0] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    $display("txn inst=0 WR addr=20 wdata=1234 aborted by reset");
    access(0, 1'b1, 8'h20, 16'h0000, 0, lat, rdm, errm);
    check("write discarded", 32'(rdm), 32'h0F0F);

    // 5. boundaries on the LAT=1, DEPTH=200 instance
    access(1, 1'b0, 8'd199, 16'h1999, 0, lat, rdm, errm);
    check("b wr latency", 32'(lat), 32'(1));
    access(1, 1'b0, 8'd200, 16'h7777, 0, lat, rdm, errm);
    check("b oor wr latency", 32'(lat), 32'(1));
    access(1, 1'b1, 8'd199, 16'h0000, 0, lat, rdm, errm);
    check("b rd latency", 32'(lat), 32'(1));
    check("b rd 199", 32'(rdm), 32'h1999);
    check("b err 199", 32'(errm), 32'(0));
    access(1, 1'b1, 8'd200, 16'h0000, 0, lat, rdm, errm);
    check("b oor rd latency", 32'(lat), 32'(1));
    check("b rd 200 zero", 32'(rdm), 32'(0));
`ifdef MEM_BOUNDS_CHK_EN
    check("b err 200", 32'(errm), 32'(1));
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
